// File: rtl/booth_mul_arbiter_if.sv
// Client-side bundle for booth_mul_arbiter.
// Carries both requesters' operand handshakes and both response handshakes,
// plus the shared result bus.
//   slave  : the arbiter's view (takes requests, drives responses)
//   master : the clients' view (drives requests, takes responses)
// WIDTH must match the arbiter's WIDTH. The product bus is 2*WIDTH bits.
interface booth_mul_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                      req0_valid;
    logic                      req0_ready;
    logic signed [WIDTH-1:0]   req0_a;
    logic signed [WIDTH-1:0]   req0_b;
    logic                      req1_valid;
    logic                      req1_ready;
    logic signed [WIDTH-1:0]   req1_a;
    logic signed [WIDTH-1:0]   req1_b;
    logic                      rsp0_valid;
    logic                      rsp0_ready;
    logic                      rsp1_valid;
    logic                      rsp1_ready;
    logic signed [2*WIDTH-1:0] rsp_product;
    logic                      rsp_error;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_product, rsp_error
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_product, rsp_error
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin scheduler that shares one Booth multiplier between two clients.
// It accepts one operand pair at a time and pulses mul_start. It then waits for
// mul_done under a watchdog and returns the product, or an error, to the
// requester that was granted.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   cli          : client handshakes and shared result bus (slave modport)
//   mul_start    : one-cycle start strobe to the multiplier
//   mul_a, mul_b : operands latched at acceptance, held until the next one
//   mul_done     : multiplier completion, only looked at while waiting
//   mul_product  : multiplier result, qualified by mul_done
//   busy         : high whenever the scheduler is not idle
module booth_mul_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    booth_mul_arbiter_if.slave        cli,
    output logic                      mul_start,
    output logic signed [WIDTH-1:0]   mul_a,
    output logic signed [WIDTH-1:0]   mul_b,
    input  logic                      mul_done,
    input  logic signed [2*WIDTH-1:0] mul_product,
    output logic                      busy
);
    // The counter has to hold TIMEOUT-1 and the one increment past it.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic                      owner;
    logic                      last_grant;
    logic [CNT_W-1:0]          wd_cnt;
    logic signed [2*WIDTH-1:0] rsp_product_q;
    logic                      rsp_error_q;
    logic                      busy_q;

    logic                      grant;
    logic                      accept;
    logic                      wd_expired;

    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt      = state;
        grant          = 1'b0;
        accept         = 1'b0;
        cli.req0_ready = 1'b0;
        cli.req1_ready = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that was not served last wins. If only
                // one requester is valid, that one wins.
                if (cli.req0_valid && cli.req1_valid) begin
                    grant = ~last_grant;
                end else begin
                    grant = cli.req1_valid;
                end
                if (cli.req0_valid || cli.req1_valid) begin
                    accept         = 1'b1;
                    cli.req0_ready = ~grant;
                    cli.req1_ready = grant;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (mul_done || wd_expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (owner ? cli.rsp1_ready : cli.rsp0_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            wd_cnt        <= '0;
            mul_a         <= '0;
            mul_b         <= '0;
            rsp_product_q <= '0;
            rsp_error_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != IDLE);
            if (accept) begin
                mul_a      <= grant ? cli.req1_a : cli.req0_a;
                mul_b      <= grant ? cli.req1_b : cli.req0_b;
                owner      <= grant;
                last_grant <= grant;
                wd_cnt     <= '0;
            end
            // Completion takes priority over a watchdog expiry in the same cycle.
            if (state == WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (mul_done) begin
                    rsp_product_q <= mul_product;
                    rsp_error_q   <= 1'b0;
                end else if (wd_expired) begin
                    rsp_product_q <= '0;
                    rsp_error_q   <= 1'b1;
                end
            end
        end
    end

    assign mul_start       = (state == ISSUE);
    assign cli.rsp0_valid  = (state == RESP) && !owner;
    assign cli.rsp1_valid  = (state == RESP) && owner;
    assign cli.rsp_product = rsp_product_q;
    assign cli.rsp_error   = rsp_error_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter. A monitor process keeps a
// transaction-level model of the scheduler. That model holds the round-robin
// rule, the latency windows and a scoreboard of expected products. Directed
// scenarios and a randomized phase drive the clients and a multiplier model.
module tb_booth_mul_arbiter;
    localparam int W  = 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mul_start, busy;
    logic signed [W-1:0]   mul_a, mul_b;
    logic                  mul_done;
    logic signed [2*W-1:0] mul_product;

    logic                  model_done = 1'b0;
    logic                  force_done = 1'b0;
    logic [2*W-1:0]        model_prod = '0;
    int                    mul_delay = 4;   // <0: random per start, 0: never answer

    booth_mul_arbiter_if #(.WIDTH(W)) bus ();

    booth_mul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cli(bus),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product), .busy(busy)
    );

    assign mul_done    = model_done | force_done;
    assign mul_product = model_done ? model_prod : 16'hA5A5;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Multiplier model: answers with a*b a chosen number of cycles after mul_start.
    initial begin : mul_model
        int pend;
        int d;
        logic [2*W-1:0] pprod;
        pend = 0;
        pprod = '0;
        forever begin
            @(negedge clk);
            if (reset) pend = 0;
            else if (mul_start) begin
                d = (mul_delay < 0) ? int'($urandom_range(0, TO + 1)) : mul_delay;
                pend = d;
                pprod = $signed(mul_a) * $signed(mul_b);
            end
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    model_done = 1'b1;
                    model_prod = pprod;
                end
            end
        end
    end

    // Scoreboard and behavioural model of the scheduler.
    typedef struct { int owner; logic [2*W-1:0] prod; } exp_t;
    exp_t sb[$];
    int   lg = 1;
    bit   mdl_busy = 0;
    bit   busy_exp = 0;
    bit   busy_nxt;
    int   acc_cyc = 0;
    bit   due_set = 0;
    int   due = 0;
    bit   mdl_err = 0;
    bit   acc0, acc1, ev0, ev1;
    int   who, expg;
    exp_t e;

    always @(negedge clk) begin : monitor
        if (reset) begin
            sb.delete();
            lg = 1;
            mdl_busy = 0;
            busy_exp = 0;
            due_set = 0;
        end else begin
            chk("busy", busy, busy_exp);
            busy_nxt = busy_exp;
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            chk("ready_without_valid", (bus.req0_ready & ~bus.req0_valid) | (bus.req1_ready & ~bus.req1_valid), 0);
            chk("dual_ready", acc0 & acc1, 0);
            if (mdl_busy) chk("ready_while_busy", bus.req0_ready | bus.req1_ready, 0);
            else if (acc0 || acc1) begin
                who = acc1 ? 1 : 0;
                if (bus.req0_valid && bus.req1_valid) expg = (lg == 1) ? 0 : 1;
                else expg = bus.req0_valid ? 0 : 1;
                chk("grant", who, expg);
                lg = who;
                e.owner = who;
                e.prod = who ? $signed(bus.req1_a) * $signed(bus.req1_b)
                             : $signed(bus.req0_a) * $signed(bus.req0_b);
                sb.push_back(e);
                mdl_busy = 1;
                acc_cyc = cyc;
                due_set = 0;
                busy_nxt = 1;
            end
            if (mul_start || (mdl_busy && cyc == acc_cyc + 1))
                chk("mul_start", mul_start, mdl_busy && cyc == acc_cyc + 1);
            // Completion window: first done between acc+2 and acc+TO+1, else watchdog.
            if (mdl_busy && !due_set && cyc >= acc_cyc + 2) begin
                if (mul_done) begin
                    due = cyc + 1; mdl_err = 0; due_set = 1;
                end else if (cyc == acc_cyc + TO + 1) begin
                    due = cyc + 1; mdl_err = 1; due_set = 1;
                end
            end
            ev0 = mdl_busy && due_set && cyc >= due && sb.size() > 0 && sb[0].owner == 0;
            ev1 = mdl_busy && due_set && cyc >= due && sb.size() > 0 && sb[0].owner == 1;
            chk("rsp0_valid", bus.rsp0_valid, ev0);
            chk("rsp1_valid", bus.rsp1_valid, ev1);
            if (ev0 || ev1) begin
                chk("rsp_product", $unsigned(bus.rsp_product), mdl_err ? 16'h0 : sb[0].prod);
                chk("rsp_error", bus.rsp_error, mdl_err);
                if ((ev0 && bus.rsp0_ready) || (ev1 && bus.rsp1_ready)) begin
                    void'(sb.pop_front());
                    mdl_busy = 0;
                    busy_nxt = 0;
                end
            end
            busy_exp = busy_nxt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, {bus.req0_ready, bus.req1_ready}, 0);
        chk({tag, "_rsp_valid"}, {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk({tag, "_rsp_product"}, $unsigned(bus.rsp_product), 0);
        chk({tag, "_rsp_error"}, bus.rsp_error, 0);
        chk({tag, "_mul_start"}, mul_start, 0);
        chk({tag, "_mul_a"}, $unsigned(mul_a), 0);
        chk({tag, "_mul_b"}, $unsigned(mul_b), 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic send(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int waited, output int acc);
        bit ok;
        tick();
        if (r == 0) begin bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; end
        else        begin bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; end
        waited = 0;
        ok = 0;
        acc = 0;
        while (!ok && waited < 60) begin
            @(negedge clk);
            ok = (r == 0) ? bus.req0_ready : bus.req1_ready;
            if (ok) acc = cyc;
            else waited++;
        end
        chk("send_accepted", ok, 1);
        tick();
        if (r == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
    endtask

    task automatic race(input logic [W-1:0] a0, b0, a1, b1, output int first);
        bit g0, g1, d0, d1;
        int n;
        tick();
        bus.req0_valid = 1; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = 1; bus.req1_a = a1; bus.req1_b = b1;
        first = -1; g0 = 0; g1 = 0; n = 0;
        while (!(g0 && g1) && n < 200) begin
            @(negedge clk);
            n++;
            d0 = bus.req0_valid && bus.req0_ready;
            d1 = bus.req1_valid && bus.req1_ready;
            if (first < 0 && d0) first = 0;
            if (first < 0 && d1) first = 1;
            tick();
            if (d0) begin g0 = 1; bus.req0_valid = 0; end
            if (d1) begin g1 = 1; bus.req1_valid = 0; end
        end
        chk("race_both_accepted", g0 && g1, 1);
    endtask

    task automatic wait_rsp(input int r);
        int n;
        bit v;
        n = 0;
        v = 0;
        while (!v && n < 60) begin
            @(negedge clk);
            v = (r == 0) ? bus.rsp0_valid : bus.rsp1_valid;
            n++;
        end
        chk("rsp_arrived", v, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb.size() != 0) && n < 200);
        chk("reached_idle", busy || sb.size() != 0, 0);
    endtask

    initial begin : global_limit
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int w, acc, first, p;
        bit a0, a1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check_zero("reset");

        // Single signed request: 7 * -3.
        mul_delay = 4;
        send(0, 8'd7, 8'hFD, w, acc);
        wait_rsp(0);
        chk("t1_latency", cyc, acc + 6);
        chk("t1_product", $unsigned(bus.rsp_product), 16'hFFEB);
        chk("t1_error", bus.rsp_error, 0);
        chk("t1_rsp1_quiet", bus.rsp1_valid, 0);
        tick(); bus.rsp0_ready = 1;
        tick(); bus.rsp0_ready = 0;

        // Round-robin from reset.
        tick(); reset = 1;
        tick(); reset = 0;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        race(8'd2, 8'd3, 8'd4, 8'd5, first);
        chk("rr_first_after_reset", first, 0);
        wait_idle();
        send(0, 8'd1, 8'd1, w, acc);
        wait_idle();
        race(8'd3, 8'd3, 8'd5, 8'd5, first);
        chk("rr_tie_after_req0", first, 1);
        wait_idle();
        send(0, 8'd2, 8'd2, w, acc);
        wait_idle();
        send(0, 8'hFE, 8'd9, w, acc);
        chk("rr_lone_req0_immediate", w, 0);
        wait_idle();

        // Backpressure on requester 1 while requester 0 waits.
        bus.rsp1_ready = 0;
        send(1, 8'h81, 8'h7F, w, acc);
        bus.req0_valid = 1; bus.req0_a = 8'd9; bus.req0_b = 8'hF7;
        wait_rsp(1);
        p = $unsigned(bus.rsp_product);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_product_stable", $unsigned(bus.rsp_product), p);
            chk("bp_rsp1_valid", bus.rsp1_valid, 1);
            chk("bp_req0_ready_low", bus.req0_ready, 0);
        end
        tick(); bus.rsp1_ready = 1;
        @(negedge clk);
        chk("bp_req0_ready_in_handshake", bus.req0_ready, 0);
        tick(); bus.rsp1_ready = 0;
        @(negedge clk);
        chk("bp_req0_accept_next", bus.req0_ready, 1);
        chk("bp_idle_busy", busy, 0);
        tick(); bus.req0_valid = 0;
        wait_idle();

        // Watchdog with a multiplier that never answers.
        mul_delay = 0;
        bus.rsp0_ready = 0;
        send(0, 8'd5, 8'd5, w, acc);
        wait_rsp(0);
        chk("wd_latency", cyc, acc + TO + 2);
        chk("wd_error", bus.rsp_error, 1);
        chk("wd_product", $unsigned(bus.rsp_product), 0);
        tick(); force_done = 1;
        @(negedge clk);
        chk("wd_late_done_rsp", {bus.rsp0_valid, bus.rsp_error}, 2'b11);
        tick(); force_done = 0; bus.rsp0_ready = 1;
        tick(); bus.rsp0_ready = 0; force_done = 1;
        @(negedge clk);
        chk("wd_late_done_idle_busy", busy, 0);
        tick(); force_done = 0;
        repeat (2) @(negedge clk);
        chk("wd_no_spurious", {bus.rsp0_valid, bus.rsp1_valid, busy}, 0);

        // Completion on the final wait cycle beats the watchdog.
        mul_delay = TO;
        bus.rsp1_ready = 1;
        send(1, 8'd3, 8'hFC, w, acc);
        wait_rsp(1);
        chk("coin_latency", cyc, acc + TO + 2);
        chk("coin_error", bus.rsp_error, 0);
        chk("coin_product", $unsigned(bus.rsp_product), 16'hFFF4);
        wait_idle();

        // Reset in the middle of a wait, then a stray done.
        mul_delay = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        send(0, 8'd6, 8'd7, w, acc);
        tick();
        tick(); reset = 1;
        tick(); reset = 0; force_done = 1;
        @(negedge clk);
        check_zero("midrst");
        tick(); force_done = 0;
        repeat (4) @(negedge clk);
        chk("midrst_no_rsp", {bus.rsp0_valid, bus.rsp1_valid, busy}, 0);
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        mul_delay = 3;
        race(8'd1, 8'd2, 8'd3, 8'd4, first);
        chk("midrst_tie_req0", first, 0);
        wait_idle();

        // Randomized traffic; the monitor checks everything.
        mul_delay = -1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            tick();
            if (a0 || !bus.req0_valid) begin
                bus.req0_valid = ($urandom_range(0, 2) != 0);
                bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
            end
            if (a1 || !bus.req1_valid) begin
                bus.req1_valid = ($urandom_range(0, 2) != 0);
                bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
            end
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        wait_idle();
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
